bfly_sequencer: RTL and testbench

BFLY_SEQUENCER -- requirements
Module: bfly_sequencer

---
 rtl/fft_pkg.sv | 22 ++
 rtl/bfly_addr_map.sv | 37 +++
 rtl/bfly_sequencer.sv | 117 +++++++++++
 tb/tb_bfly_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the 256-point radix-2 FFT sequencer.
//   FFT_POINTS / FFT_STAGES : transform size and number of radix-2 stages
//   ADDR_W / TW_W           : sample-address and twiddle-index widths
//   seq_state_e             : sequencer FSM state encoding
package fft_pkg;

    localparam int unsigned FFT_POINTS = 256;
    localparam int unsigned FFT_STAGES = 8;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned TW_W       = 7;
    localparam int unsigned STAGE_W    = 3;
    localparam int unsigned BIDX_W     = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STROBE = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/bfly_addr_map.sv
// Radix-2 DIT butterfly address generator (purely combinational).
//   stage_i       : stage s (0..7)
//   bfly_idx_i    : butterfly index k within the stage (0..127)
//   addr_a_o      : top-leg sample address
//   addr_b_o      : bottom-leg sample address (addr_a + span)
//   twiddle_idx_o : twiddle ROM index
module bfly_addr_map
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] stage_i,
    input  logic [BIDX_W-1:0]  bfly_idx_i,
    output logic [ADDR_W-1:0]  addr_a_o,
    output logic [ADDR_W-1:0]  addr_b_o,
    output logic [TW_W-1:0]    twiddle_idx_o
);

    logic [ADDR_W-1:0] k_ext;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] low_mask;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] tw_full;

    always_comb begin
        k_ext    = {1'b0, bfly_idx_i};
        span     = ADDR_W'(1) << stage_i;
        low_mask = span - ADDR_W'(1);
        // Insert a zero bit at position s of k: upper bits move up one place.
        // Shift amount is widened so s+1 = 8 does not wrap to 0.
        addr_a   = ((k_ext >> stage_i) << ({1'b0, stage_i} + 4'd1)) | (k_ext & low_mask);
        tw_full  = (k_ext & low_mask) << (3'd7 - stage_i);
    end

    assign addr_a_o      = addr_a;
    assign addr_b_o      = addr_a + span;
    assign twiddle_idx_o = tw_full[TW_W-1:0];

endmodule

// File: rtl/bfly_sequencer.sv
// Butterfly sequencer for a 256-point radix-2 DIT FFT.
// Walks 8 stages x 128 butterflies, waits BFLY_LAT cycles of datapath
// write-back after each stage, then pulses stage_strobe.
//   clk, reset   : clock, synchronous active-high reset
//   start        : one-cycle run request, honoured only in IDLE
//   bfly_ready   : datapath accepts the presented butterfly
//   bfly_valid   : addr_a/addr_b/twiddle_idx hold a valid butterfly
//   addr_a/addr_b/twiddle_idx : butterfly addresses and twiddle index
//   stage_strobe : one pulse per completed stage (stage counter enable)
//   clear        : one pulse at FFT start (stage counter clear)
//   busy         : high outside IDLE
//   fft_done     : one pulse after the 8th stage strobe
module bfly_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned BFLY_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              bfly_ready,
    output logic              bfly_valid,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   twiddle_idx,
    output logic              stage_strobe,
    output logic              clear,
    output logic              busy,
    output logic              fft_done
);

    localparam logic [BIDX_W-1:0]  K_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = '1;

    seq_state_e         state_q, state_d;
    logic [STAGE_W-1:0] s_q, s_d;
    logic [BIDX_W-1:0]  k_q, k_d;
    logic [3:0]         drain_q, drain_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = '0;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bfly_ready) begin
                    if (k_q == K_LAST) begin
                        drain_d = 4'(BFLY_LAT);
                        state_d = ST_DRAIN;
                    end else begin
                        k_d = k_q + BIDX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (s_q == S_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    s_d     = s_q + STAGE_W'(1);
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    bfly_addr_map u_addr_map (
        .stage_i       (s_q),
        .bfly_idx_i    (k_q),
        .addr_a_o      (addr_a),
        .addr_b_o      (addr_b),
        .twiddle_idx_o (twiddle_idx)
    );

    // Status outputs are masked by reset so they read 0 even in the reset
    // cycle before the state register has been forced to IDLE.
    assign bfly_valid   = (state_q == ST_RUN)    & ~reset;
    assign stage_strobe = (state_q == ST_STROBE) & ~reset;
    assign fft_done     = (state_q == ST_DONE)   & ~reset;
    assign busy         = (state_q != ST_IDLE)   & ~reset;
    assign clear        = (state_q == ST_IDLE)   & start & ~reset;

endmodule

// File: tb/tb_bfly_sequencer.sv
module tb_bfly_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bfly_ready;
    logic       bfly_valid;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic [6:0] twiddle_idx;
    logic       stage_strobe;
    logic       clear;
    logic       busy;
    logic       fft_done;

    int checks   = 0;
    int failures = 0;

    logic [22:0] exp_q[$];
    logic [3:0]  stage_cnt = 4'hF;

    always #5 clk = ~clk;

    bfly_sequencer #(.BFLY_LAT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bfly_ready   (bfly_ready),
        .bfly_valid   (bfly_valid),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .twiddle_idx  (twiddle_idx),
        .stage_strobe (stage_strobe),
        .clear        (clear),
        .busy         (busy),
        .fft_done     (fft_done)
    );

    // Stage counter driven by the sequencer's clear / stage_strobe.
    always @(posedge clk) begin
        if (clear) stage_cnt <= 4'd0;
        else if (stage_strobe) stage_cnt <= stage_cnt + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Butterfly k of stage s: split k into high/low parts around the span.
    function automatic logic [22:0] model(input int s, input int k);
        int span, lo, hi, a, b, tw;
        span = 1 << s;
        lo   = k % span;
        hi   = k / span;
        a    = hi * 2 * span + lo;
        b    = a + span;
        tw   = lo * (128 / span);
        return {a[7:0], b[7:0], tw[6:0]};
    endfunction

    task automatic push_stage(input int s);
        for (int k = 0; k < 128; k++) exp_q.push_back(model(s, k));
    endtask

    // One transform. rnd: random ready stalls; mid_start: cycle of an extra
    // start pulse (also pulses start during the DONE cycle); abort_at: cycle
    // at which reset is asserted.
    task automatic run_fft(input bit rnd, input int mid_start, input int abort_at);
        int cyc, p, strobes, hs, done_cyc;
        bit fin, aborted, prev_v, prev_r;
        logic [22:0] prev_addr;
        logic [255:0] seen;
        strobes = 0; hs = 0; done_cyc = -1; fin = 0; aborted = 0;
        prev_v = 0; prev_r = 0; prev_addr = '0; seen = '0;
        exp_q.delete();

        start = 1'b1;
        bfly_ready = 1'b1;
        #1;
        chk("clear_at_start", {31'd0, clear}, 1);
        chk("busy_idle_at_start", {31'd0, busy}, 0);
        push_stage(0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("stage_cnt_after_clear", {28'd0, stage_cnt}, 0);

        cyc = 1;
        while (!fin && !aborted && cyc < 6000) begin
            bfly_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = (cyc == mid_start) || (mid_start >= 0 && cyc == 1065);
            if (cyc == abort_at) reset = 1'b1;
            #1;
            if (cyc == abort_at) begin
                chk("outputs_in_reset", {27'd0, bfly_valid, stage_strobe, clear, busy, fft_done}, 0);
                aborted = 1;
            end else begin
                if (start) chk("clear_ignored", {31'd0, clear}, 0);
                if (!rnd) begin
                    p = (cyc - 1) % 133;
                    chk("valid_timing", {31'd0, bfly_valid}, {31'd0, (cyc <= 1064 && p < 128)});
                    chk("strobe_timing", {31'd0, stage_strobe}, {31'd0, (cyc <= 1064 && p == 132)});
                    chk("done_timing", {31'd0, fft_done}, {31'd0, (cyc == 1065)});
                    chk("busy_timing", {31'd0, busy}, 1);
                    if (cyc == 6)   chk("s0_k5",  {9'd0, addr_a, addr_b, twiddle_idx}, {9'd0, 8'd10, 8'd11, 7'd0});
                    if (cyc == 413) chk("s3_k13", {9'd0, addr_a, addr_b, twiddle_idx}, {9'd0, 8'd21, 8'd29, 7'd80});
                    if (cyc == 937) chk("s7_k5",  {9'd0, addr_a, addr_b, twiddle_idx}, {9'd0, 8'd5, 8'd133, 7'd5});
                end
                if (prev_v && !prev_r) begin
                    chk("stall_valid", {31'd0, bfly_valid}, 1);
                    chk("stall_hold", {9'd0, addr_a, addr_b, twiddle_idx}, {9'd0, prev_addr});
                end
                if (bfly_valid && bfly_ready) begin
                    hs++;
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else chk("addr", {9'd0, addr_a, addr_b, twiddle_idx}, {9'd0, exp_q.pop_front()});
                    if (seen[addr_a] || seen[addr_b]) chk("dup_addr", {30'd0, seen[addr_a], seen[addr_b]}, 0);
                    seen[addr_a] = 1'b1;
                    seen[addr_b] = 1'b1;
                end
                if (stage_strobe) begin
                    chk("stage_cnt", {28'd0, stage_cnt}, strobes);
                    strobes++;
                    chk("stage_cover", {31'd0, &seen}, 1);
                    chk("sb_empty", exp_q.size(), 0);
                    seen = '0;
                    if (strobes < 8) push_stage(strobes);
                end
                if (fft_done) begin
                    chk("strobe_count", strobes, 8);
                    chk("handshakes", hs, 1024);
                    fin = 1;
                    done_cyc = cyc;
                end
                prev_v = bfly_valid;
                prev_r = bfly_ready;
                prev_addr = {addr_a, addr_b, twiddle_idx};
            end
            @(posedge clk); #1;
            cyc++;
        end

        start = 1'b0;
        if (aborted) begin
            #1;
            chk("reset_hold", {27'd0, bfly_valid, stage_strobe, clear, busy, fft_done}, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            for (int i = 0; i < 300; i++) begin
                #1;
                chk("post_abort_quiet", {28'd0, bfly_valid, stage_strobe, busy, fft_done}, 0);
                @(posedge clk); #1;
            end
        end else begin
            if (!fin) chk("timeout", 0, 1);
            if (!rnd) chk("done_cycle", done_cyc, 1065);
            #1;
            chk("stage_cnt_final", {28'd0, stage_cnt}, 8);
            chk("busy_after_done", {31'd0, busy}, 0);
            chk("no_clear_after_done", {31'd0, clear}, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        bfly_ready = 1'b1;
        #1;
        chk("reset_outputs_0", {27'd0, bfly_valid, stage_strobe, clear, busy, fft_done}, 0);
        @(posedge clk); #1;
        chk("reset_outputs_1", {27'd0, bfly_valid, stage_strobe, clear, busy, fft_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("first_cycle_after_reset", {27'd0, bfly_valid, stage_strobe, clear, busy, fft_done}, 0);
        @(posedge clk); #1;

        run_fft(1'b0, -1, -1);   // nominal timing and spot addresses
        run_fft(1'b0, 50, -1);   // extra start mid-RUN and during DONE
        run_fft(1'b1, -1, -1);   // random ready stalls
        run_fft(1'b0, -1, 661);  // reset in stage 4 DRAIN
        run_fft(1'b0, -1, -1);   // fresh transform after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
